// File: rtl/conv_encoder_k7.sv
// Rate-1/2 feed-forward convolutional encoder (K=7, G0=171, G1=133 octal).
// One info bit in, one code pair out; optional zero tail drives the trellis back to state 0.
module conv_encoder_k7 #(
    parameter int             K       = 7,
    parameter logic [K-1:0]   G0      = 7'o171,
    parameter logic [K-1:0]   G1      = 7'o133,
    parameter bit             TAIL_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_pair,
    output logic       out_last
);

    localparam int CW = $clog2(K);

    typedef enum logic [1:0] {
        IDLE,
        ENCODE,
        FLUSH
    } state_t;

    state_t        state, state_nxt;
    logic [K-2:0]  sr, sr_nxt;
    logic [CW-1:0] tail_cnt, tail_cnt_nxt;
    logic          slot_free;
    logic          in_hs;
    logic          flush_ld;
    logic          load;
    logic          last_nxt;
    logic          u;
    logic [K-1:0]  w;
    logic [1:0]    pair;

    // The output register is the only buffer: a pair can be loaded whenever
    // it is empty or being drained this very cycle.
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = !rst && (state != FLUSH) && slot_free;
    assign in_hs     = in_valid && in_ready;
    assign flush_ld  = (state == FLUSH) && slot_free;
    assign load      = in_hs || flush_ld;

    // w[K-1] is the current input, w[0] the oldest stored bit.
    assign u    = (state == FLUSH) ? 1'b0 : in_bit;
    assign w    = {u, sr};
    assign pair = {^(w & G0), ^(w & G1)};

    always_comb begin
        state_nxt    = state;
        sr_nxt       = sr;
        tail_cnt_nxt = tail_cnt;
        last_nxt     = 1'b0;
        if (in_hs) begin
            sr_nxt    = {in_bit, sr[K-2:1]};
            state_nxt = ENCODE;
            if (in_last) begin
                if (TAIL_EN) begin
                    state_nxt    = FLUSH;
                    tail_cnt_nxt = CW'(K - 1);
                end else begin
                    last_nxt  = 1'b1;
                    sr_nxt    = '0;
                    state_nxt = IDLE;
                end
            end
        end else if (flush_ld) begin
            sr_nxt       = {1'b0, sr[K-2:1]};
            tail_cnt_nxt = tail_cnt - CW'(1);
            if (tail_cnt == CW'(1)) begin
                last_nxt  = 1'b1;
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            tail_cnt  <= '0;
            out_valid <= 1'b0;
            out_pair  <= 2'b00;
            out_last  <= 1'b0;
        end else begin
            state    <= state_nxt;
            sr       <= sr_nxt;
            tail_cnt <= tail_cnt_nxt;
            if (load) begin
                out_valid <= 1'b1;
                out_pair  <= pair;
                out_last  <= last_nxt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder_k7.sv
// Scoreboard bench for conv_encoder_k7: one instance with tail flushing, one without.
// Expected pairs come from a windowed model of each frame started from the zero state.
module tb_conv_encoder_k7;

    localparam logic [6:0] G0 = 7'o171;
    localparam logic [6:0] G1 = 7'o133;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       iv_t = 1'b0, ib_t = 1'b0, il_t = 1'b0, or_t = 1'b1;
    logic       ir_t, ov_t, ol_t;
    logic [1:0] op_t;
    logic       iv_n = 1'b0, ib_n = 1'b0, il_n = 1'b0, or_n = 1'b1;
    logic       ir_n, ov_n, ol_n;
    logic [1:0] op_n;

    conv_encoder_k7 #(.TAIL_EN(1'b1)) dut_t (
        .clk(clk), .rst(rst),
        .in_valid(iv_t), .in_ready(ir_t), .in_bit(ib_t), .in_last(il_t),
        .out_valid(ov_t), .out_ready(or_t), .out_pair(op_t), .out_last(ol_t)
    );

    conv_encoder_k7 #(.TAIL_EN(1'b0)) dut_n (
        .clk(clk), .rst(rst),
        .in_valid(iv_n), .in_ready(ir_n), .in_bit(ib_n), .in_last(il_n),
        .out_valid(ov_n), .out_ready(or_n), .out_pair(op_n), .out_last(ol_n)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pc_t = 0, lc_t = 0, pc_n = 0, lc_n = 0;
    int first_t = 0, last_hs_t = 0;
    bit mark_t = 0;
    bit done = 0;
    bit fb[$];
    logic [2:0] q_t[$], q_n[$], log_t[$], log_n[$];
    logic [2:0] e_t, e_n;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst && ov_t && or_t) begin
            log_t.push_back({op_t, ol_t});
            pc_t++;
            if (ol_t) lc_t++;
            if (mark_t) begin first_t = cyc; mark_t = 0; end
            last_hs_t = cyc;
            total++;
            if (q_t.size() == 0) begin
                bad++;
                $display("FAIL sb_tail unexpected pair got=%b exp=none", {op_t, ol_t});
            end else begin
                e_t = q_t.pop_front();
                if ({op_t, ol_t} !== e_t) begin
                    bad++;
                    $display("FAIL sb_tail pair/last got=%b exp=%b", {op_t, ol_t}, e_t);
                end
            end
        end
        if (!rst && ov_n && or_n) begin
            log_n.push_back({op_n, ol_n});
            pc_n++;
            if (ol_n) lc_n++;
            total++;
            if (q_n.size() == 0) begin
                bad++;
                $display("FAIL sb_notail unexpected pair got=%b exp=none", {op_n, ol_n});
            end else begin
                e_n = q_n.pop_front();
                if ({op_n, ol_n} !== e_n) begin
                    bad++;
                    $display("FAIL sb_notail pair/last got=%b exp=%b", {op_n, ol_n}, e_n);
                end
            end
        end
    end

    task automatic push_exp(input bit sel);
        int n, tot;
        logic [6:0] w;
        logic [2:0] e;
        n   = fb.size();
        tot = sel ? n + 6 : n;
        for (int i = 0; i < tot; i++) begin
            for (int j = 0; j < 7; j++) begin
                int idx = i - j;
                w[6-j] = (idx >= 0 && idx < n) ? fb[idx] : 1'b0;
            end
            e = {^(w & G0), ^(w & G1), (i == tot - 1)};
            if (sel) q_t.push_back(e); else q_n.push_back(e);
        end
    endtask

    task automatic send(input bit sel, input bit hold);
        bit hs;
        int guard;
        for (int i = 0; i < fb.size(); i++) begin
            if (sel) begin iv_t = 1'b1; ib_t = fb[i]; il_t = (i == fb.size() - 1); end
            else     begin iv_n = 1'b1; ib_n = fb[i]; il_n = (i == fb.size() - 1); end
            hs = 0;
            guard = 0;
            while (!hs) begin
                @(negedge clk);
                hs = sel ? ir_t : ir_n;
                @(posedge clk);
                #1;
                guard++;
                if (!hs && guard > 300) begin
                    total++;
                    bad++;
                    $display("FAIL send_timeout got=in_ready_low exp=in_ready_high");
                    iv_t = 1'b0; iv_n = 1'b0;
                    return;
                end
            end
        end
        if (!hold) begin
            if (sel) begin iv_t = 1'b0; il_t = 1'b0; end
            else     begin iv_n = 1'b0; il_n = 1'b0; end
        end
    endtask

    task automatic drain(input bit sel);
        bit ok = 0;
        for (int g = 0; g < 400 && !ok; g++) begin
            ok = sel ? (q_t.size() == 0 && !ov_t) : (q_n.size() == 0 && !ov_n);
            if (!ok) begin @(posedge clk); #1; end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL drain_timeout sel=%0d got=pending exp=empty", sel);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total += 8;
        if (ov_t !== 1'b0)  begin bad++; $display("FAIL reset_ov_t got=%b exp=0", ov_t); end
        if (op_t !== 2'b00) begin bad++; $display("FAIL reset_op_t got=%b exp=00", op_t); end
        if (ol_t !== 1'b0)  begin bad++; $display("FAIL reset_ol_t got=%b exp=0", ol_t); end
        if (ir_t !== 1'b0)  begin bad++; $display("FAIL reset_ir_t got=%b exp=0", ir_t); end
        if (ov_n !== 1'b0)  begin bad++; $display("FAIL reset_ov_n got=%b exp=0", ov_n); end
        if (op_n !== 2'b00) begin bad++; $display("FAIL reset_op_n got=%b exp=00", op_n); end
        if (ol_n !== 1'b0)  begin bad++; $display("FAIL reset_ol_n got=%b exp=0", ol_n); end
        if (ir_n !== 1'b0)  begin bad++; $display("FAIL reset_ir_n got=%b exp=0", ir_n); end
        rst = 1'b0;
        #1;
        total += 2;
        if (ir_t !== 1'b1) begin bad++; $display("FAIL post_reset_ir_t got=%b exp=1", ir_t); end
        if (ir_n !== 1'b1) begin bad++; $display("FAIL post_reset_ir_n got=%b exp=1", ir_n); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_impulse();
        logic [1:0] imp [7] = '{2'b11, 2'b10, 2'b11, 2'b11, 2'b00, 2'b01, 2'b11};
        int c0, l0;
        log_t.delete();
        c0 = pc_t; l0 = lc_t;
        fb = '{1'b1};
        push_exp(1'b1);
        send(1'b1, 1'b0);
        drain(1'b1);
        total += 3;
        if (pc_t - c0 != 7) begin bad++; $display("FAIL impulse_count got=%0d exp=7", pc_t - c0); end
        if (lc_t - l0 != 1) begin bad++; $display("FAIL impulse_lasts got=%0d exp=1", lc_t - l0); end
        if (ir_t !== 1'b1)  begin bad++; $display("FAIL impulse_ready_after got=%b exp=1", ir_t); end
        for (int i = 0; i < 7 && i < log_t.size(); i++) begin
            total++;
            if (log_t[i] !== {imp[i], (i == 6)}) begin
                bad++;
                $display("FAIL impulse_pair%0d got=%b exp=%b", i, log_t[i], {imp[i], (i == 6)});
            end
        end
    endtask

    task automatic test_all_ones();
        log_t.delete();
        fb.delete();
        repeat (7) fb.push_back(1'b1);
        push_exp(1'b1);
        send(1'b1, 1'b0);
        drain(1'b1);
        total++;
        if (log_t.size() != 13) begin
            bad++;
            $display("FAIL ones_count got=%0d exp=13", log_t.size());
        end else begin
            total += 3;
            if (log_t[0][2:1] !== 2'b11) begin bad++; $display("FAIL ones_pair0 got=%b exp=11", log_t[0][2:1]); end
            if (log_t[1][2:1] !== 2'b01) begin bad++; $display("FAIL ones_pair1 got=%b exp=01", log_t[1][2:1]); end
            if (log_t[6][2:1] !== 2'b11) begin bad++; $display("FAIL ones_pair6 got=%b exp=11", log_t[6][2:1]); end
        end
        total++;
        if (dut_t.sr !== 6'd0) begin bad++; $display("FAIL ones_final_sr got=%b exp=000000", dut_t.sr); end
    endtask

    task automatic test_backpressure();
        logic [2:0] saved;
        int c0 = pc_t;
        fb = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        push_exp(1'b1);
        fork
            send(1'b1, 1'b0);
            begin
                repeat (4) @(posedge clk);
                #1;
                or_t  = 1'b0;
                saved = {op_t, ol_t};
                for (int k = 0; k < 3; k++) begin
                    @(posedge clk);
                    #1;
                    total += 3;
                    if (ov_t !== 1'b1) begin bad++; $display("FAIL bp_valid c%0d got=%b exp=1", k, ov_t); end
                    if ({op_t, ol_t} !== saved) begin
                        bad++;
                        $display("FAIL bp_stable c%0d got=%b exp=%b", k, {op_t, ol_t}, saved);
                    end
                    if (ir_t !== 1'b0) begin bad++; $display("FAIL bp_ready c%0d got=%b exp=0", k, ir_t); end
                end
                or_t = 1'b1;
            end
        join
        drain(1'b1);
        total++;
        if (pc_t - c0 != 16) begin bad++; $display("FAIL bp_count got=%0d exp=16", pc_t - c0); end
    endtask

    task automatic test_back_to_back();
        int c0 = pc_t, l0 = lc_t;
        mark_t = 1;
        fb = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        push_exp(1'b1);
        send(1'b1, 1'b1);
        fb = '{1'b1, 1'b1, 1'b0};
        push_exp(1'b1);
        send(1'b1, 1'b0);
        drain(1'b1);
        total += 3;
        if (pc_t - c0 != 20) begin bad++; $display("FAIL b2b_count got=%0d exp=20", pc_t - c0); end
        if (lc_t - l0 != 2)  begin bad++; $display("FAIL b2b_lasts got=%0d exp=2", lc_t - l0); end
        if (last_hs_t - first_t != 19) begin
            bad++;
            $display("FAIL b2b_gap span got=%0d exp=19", last_hs_t - first_t);
        end
    endtask

    task automatic test_reset_flush();
        int l0 = lc_t;
        bit hit = 0;
        fb = '{1'b1};
        push_exp(1'b1);
        send(1'b1, 1'b0);
        for (int g = 0; g < 20 && !hit; g++) begin
            hit = (dut_t.tail_cnt == 3'd3);
            if (!hit) begin @(posedge clk); #1; end
        end
        total++;
        if (!hit) begin bad++; $display("FAIL rstflush_reach got=cnt%0d exp=cnt3", dut_t.tail_cnt); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        total += 3;
        if (ov_t !== 1'b0) begin bad++; $display("FAIL rstflush_valid got=%b exp=0", ov_t); end
        if (ol_t !== 1'b0) begin bad++; $display("FAIL rstflush_last got=%b exp=0", ol_t); end
        if (ir_t !== 1'b0) begin bad++; $display("FAIL rstflush_ready got=%b exp=0", ir_t); end
        rst = 1'b0;
        q_t.delete();
        total++;
        if (lc_t != l0) begin bad++; $display("FAIL rstflush_nolast got=%0d exp=%0d", lc_t, l0); end
        test_impulse();
    endtask

    task automatic test_random_bp();
        int c0 = pc_t, l0 = lc_t;
        fb.delete();
        repeat (20) fb.push_back(1'($urandom_range(0, 1)));
        push_exp(1'b1);
        done = 0;
        fork
            begin send(1'b1, 1'b0); done = 1; end
            begin
                int k = 0;
                while (!done && k < 1000) begin
                    @(posedge clk);
                    #1;
                    or_t = 1'($urandom_range(0, 1));
                    k++;
                end
                or_t = 1'b1;
            end
        join
        drain(1'b1);
        total += 2;
        if (pc_t - c0 != 26) begin bad++; $display("FAIL rndbp_count got=%0d exp=26", pc_t - c0); end
        if (lc_t - l0 != 1)  begin bad++; $display("FAIL rndbp_lasts got=%0d exp=1", lc_t - l0); end
    endtask

    task automatic test_no_tail();
        int c0 = pc_n, l0 = lc_n;
        log_n.delete();
        fb.delete();
        repeat (100) fb.push_back(1'($urandom_range(0, 1)));
        push_exp(1'b0);
        send(1'b0, 1'b1);
        fb.delete();
        repeat (100) fb.push_back(1'($urandom_range(0, 1)));
        push_exp(1'b0);
        send(1'b0, 1'b0);
        drain(1'b0);
        total += 2;
        if (pc_n - c0 != 200) begin bad++; $display("FAIL notail_count got=%0d exp=200", pc_n - c0); end
        if (lc_n - l0 != 2)   begin bad++; $display("FAIL notail_lasts got=%0d exp=2", lc_n - l0); end
        if (log_n.size() >= 100) begin
            total += 2;
            if (log_n[99][0] !== 1'b1) begin bad++; $display("FAIL notail_last100 got=%b exp=1", log_n[99][0]); end
            if (log_n[98][0] !== 1'b0) begin bad++; $display("FAIL notail_last99 got=%b exp=0", log_n[98][0]); end
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_all_ones();
        test_backpressure();
        test_back_to_back();
        test_reset_flush();
        test_random_bp();
        test_no_tail();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
